// File: rtl/chat2snack_status_tx.sv
// rtl/chat2snack_status_tx.sv - 8N1 UART transmitter for 16-bit status packets, low byte first.
// Optional macro STATUS_TX_CHECKSUM_EN appends an XOR checksum byte after the high byte.
module chat2snack_status_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send_req,
  input  logic [15:0] status_word,
  output logic        uart_tx_pin,
  output logic        busy,
  output logic        done_pulse,
  output logic        overrun
);

`ifdef STATUS_TX_CHECKSUM_EN
  localparam int NUM_BYTES = 3;
`else
  localparam int NUM_BYTES = 2;
`endif
  localparam int SW = 8 * NUM_BYTES;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]    BYTE_LAST = 2'(NUM_BYTES - 1);

  typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [SW-1:0] shadow;
  logic          pending_valid;
  logic [15:0]   pending_word;
  logic [7:0]    cur_byte;
  logic          cnt_done;
  logic          in_frame;

  function automatic logic [SW-1:0] packet(input logic [15:0] w);
`ifdef STATUS_TX_CHECKSUM_EN
    return {w[7:0] ^ w[15:8], w};
`else
    return w;
`endif
  endfunction

  always_comb begin
    cur_byte = shadow[byte_idx*8 +: 8];
    cnt_done = (cnt == CNT_LAST);
    in_frame = (state == START_BIT) || (state == DATA_BITS) || (state == STOP_BIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      byte_idx      <= '0;
      shadow        <= '0;
      pending_valid <= 1'b0;
      pending_word  <= '0;
      uart_tx_pin   <= 1'b1;
      busy          <= 1'b0;
      done_pulse    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      // Requests arriving mid-packet park in a one-deep slot; a second one clobbers it.
      if (send_req && in_frame) begin
        pending_word  <= status_word;
        pending_valid <= 1'b1;
        if (pending_valid) overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (send_req) begin
            shadow      <= packet(status_word);
            byte_idx    <= '0;
            cnt         <= '0;
            uart_tx_pin <= 1'b0;
            busy        <= 1'b1;
            state       <= START_BIT;
          end
        end
        START_BIT: begin
          if (cnt_done) begin
            cnt         <= '0;
            bit_idx     <= '0;
            uart_tx_pin <= cur_byte[0];
            state       <= DATA_BITS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA_BITS: begin
          if (cnt_done) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx_pin <= 1'b1;
              state       <= STOP_BIT;
            end else begin
              bit_idx     <= bit_idx + 3'd1;
              uart_tx_pin <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP_BIT: begin
          if (cnt_done) begin
            cnt <= '0;
            if (byte_idx != BYTE_LAST) begin
              byte_idx    <= byte_idx + 2'd1;
              uart_tx_pin <= 1'b0;
              state       <= START_BIT;
            end else begin
              busy       <= 1'b0;
              done_pulse <= 1'b1;
              state      <= DONE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          byte_idx <= '0;
          cnt      <= '0;
          // A fresh request in this cycle wins over the parked one, which is dropped silently.
          if (send_req) begin
            shadow        <= packet(status_word);
            pending_valid <= 1'b0;
            uart_tx_pin   <= 1'b0;
            busy          <= 1'b1;
            state         <= START_BIT;
          end else if (pending_valid) begin
            shadow        <= packet(pending_word);
            pending_valid <= 1'b0;
            uart_tx_pin   <= 1'b0;
            busy          <= 1'b1;
            state         <= START_BIT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chat2snack_status_tx.sv
// tb/tb_chat2snack_status_tx.sv - scoreboard bench for chat2snack_status_tx at CLKS_PER_BIT=4.
module tb_chat2snack_status_tx;
  localparam int CPB = 4;
`ifdef STATUS_TX_CHECKSUM_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int D = NB * 10 * CPB + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        send_req = 1'b0;
  logic [15:0] status_word = 16'h0000;
  logic        uart_tx_pin, busy, done_pulse, overrun;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;

  logic [7:0] exp_q[$];
  logic [8:0] rx_q[$];
  int         rxt_q[$];

  chat2snack_status_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .send_req(send_req), .status_word(status_word),
    .uart_tx_pin(uart_tx_pin), .busy(busy), .done_pulse(done_pulse), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Independent line receiver: samples each bit mid-period, flags framing in bit 8.
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  int         rx_t0 = 0;
  logic [7:0] rx_byte;
  bit         rx_ok;
  always @(negedge clk) begin
    if (rst) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (uart_tx_pin == 1'b0) begin
        rx_active = 1'b1; rx_cnt = 0; rx_t0 = cyc; rx_ok = 1'b1;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == CPB / 2 && uart_tx_pin !== 1'b0) rx_ok = 1'b0;
      for (int i = 0; i < 8; i++)
        if (rx_cnt == CPB * (i + 1) + CPB / 2) rx_byte[i] = uart_tx_pin;
      if (rx_cnt == CPB * 9 + CPB / 2) begin
        if (uart_tx_pin !== 1'b1) rx_ok = 1'b0;
        rx_q.push_back({rx_ok, rx_byte});
        rxt_q.push_back(rx_t0);
      end
      if (rx_cnt == CPB * 10 - 1) rx_active = 1'b0;
    end
  end

  task automatic to_cycle(input int c);
    while (cyc < base + c) @(negedge clk);
  endtask

  task automatic push_pkt(input logic [15:0] w);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
`ifdef STATUS_TX_CHECKSUM_EN
    exp_q.push_back(w[7:0] ^ w[15:8]);
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (uart_tx_pin !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", uart_tx_pin); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (done_pulse !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_pulse); end
    vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single(input logic [15:0] w, input bit check_start);
    logic [8:0] got; logic [7:0] e; int t;
    rxt_q.delete(); rx_q.delete();
    @(negedge clk); base = cyc;
    send_req = 1'b1; status_word = w; push_pkt(w);
    to_cycle(1);
    send_req = 1'b0; status_word = ~w;
    vectors++; if (uart_tx_pin !== 1'b0) begin errors++; $display("FAIL single_start_tx got %b exp 0", uart_tx_pin); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_first got %b exp 1", busy); end
    to_cycle(D - 1);
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_last got %b exp 1", busy); end
    vectors++; if (done_pulse !== 1'b0) begin errors++; $display("FAIL single_done_early got %b exp 0", done_pulse); end
    to_cycle(D);
    vectors++; if (done_pulse !== 1'b1 || busy !== 1'b0 || uart_tx_pin !== 1'b1)
      begin errors++; $display("FAIL single_done_cycle got done=%b busy=%b tx=%b exp 1 0 1", done_pulse, busy, uart_tx_pin); end
    to_cycle(D + 1);
    vectors++; if (done_pulse !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_after_done got done=%b busy=%b exp 0 0", done_pulse, busy); end
    if (check_start) begin
      t = (rxt_q.size() > 0) ? rxt_q[0] - base : -1;
      vectors++; if (t !== 1) begin errors++; $display("FAIL single_start_cycle got %0d exp 1", t); end
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); e = exp_q.pop_front();
      vectors++; if (got !== {1'b1, e}) begin errors++; $display("FAIL single_byte got %h exp %h", got, {1'b1, e}); end
    end
    vectors++; if (rx_q.size() != 0 || exp_q.size() != 0) begin errors++; $display("FAIL single_count got rx_left=%0d exp_left=%0d exp 0 0", rx_q.size(), exp_q.size()); end
  endtask

  task automatic test_pending;
    logic [8:0] got; logic [7:0] e; int t;
    rxt_q.delete(); rx_q.delete();
    @(negedge clk); base = cyc;
    send_req = 1'b1; status_word = 16'h8123; push_pkt(16'h8123);
    to_cycle(1); send_req = 1'b0;
    to_cycle(40); send_req = 1'b1; status_word = 16'h0007; push_pkt(16'h0007);
    to_cycle(41); send_req = 1'b0;
    to_cycle(D);
    vectors++; if (done_pulse !== 1'b1) begin errors++; $display("FAIL pend_done got %b exp 1", done_pulse); end
    to_cycle(D + 1);
    vectors++; if (uart_tx_pin !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL pend_restart got tx=%b busy=%b exp 0 1", uart_tx_pin, busy); end
    vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL pend_overrun got %b exp 0", overrun); end
    to_cycle(2 * D);
    vectors++; if (done_pulse !== 1'b1) begin errors++; $display("FAIL pend_done2 got %b exp 1", done_pulse); end
    t = (rxt_q.size() > NB) ? rxt_q[NB] - base : -1;
    vectors++; if (t !== D + 1) begin errors++; $display("FAIL pend_second_start got %0d exp %0d", t, D + 1); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); e = exp_q.pop_front();
      vectors++; if (got !== {1'b1, e}) begin errors++; $display("FAIL pend_byte got %h exp %h", got, {1'b1, e}); end
    end
    vectors++; if (rx_q.size() != 0 || exp_q.size() != 0) begin errors++; $display("FAIL pend_count got rx_left=%0d exp_left=%0d exp 0 0", rx_q.size(), exp_q.size()); end
  endtask

  task automatic test_overrun;
    logic [8:0] got; logic [7:0] e;
    rx_q.delete();
    @(negedge clk); base = cyc;
    send_req = 1'b1; status_word = 16'h8123; push_pkt(16'h8123);
    to_cycle(1); send_req = 1'b0;
    to_cycle(10); send_req = 1'b1; status_word = 16'h0001;
    to_cycle(11); send_req = 1'b0;
    vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b exp 0", overrun); end
    to_cycle(20); send_req = 1'b1; status_word = 16'h0002; push_pkt(16'h0002);
    to_cycle(21); send_req = 1'b0;
    vectors++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", overrun); end
    to_cycle(2 * D + 2);
    vectors++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); e = exp_q.pop_front();
      vectors++; if (got !== {1'b1, e}) begin errors++; $display("FAIL ovr_byte got %h exp %h", got, {1'b1, e}); end
    end
    vectors++; if (rx_q.size() != 0 || exp_q.size() != 0) begin errors++; $display("FAIL ovr_count got rx_left=%0d exp_left=%0d exp 0 0", rx_q.size(), exp_q.size()); end
  endtask

  task automatic test_midreset;
    rx_q.delete(); exp_q.delete();
    @(negedge clk); base = cyc;
    send_req = 1'b1; status_word = 16'hA5C3;
    to_cycle(1); send_req = 1'b0;
    to_cycle(30);
    rst = 1'b1;
    #1;
    vectors++; if (uart_tx_pin !== 1'b1 || busy !== 1'b0 || done_pulse !== 1'b0)
      begin errors++; $display("FAIL mid_rst got tx=%b busy=%b done=%b exp 1 0 0", uart_tx_pin, busy, done_pulse); end
    vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_rst_overrun got %b exp 0", overrun); end
    to_cycle(32); rst = 1'b0;
    to_cycle(90);
    vectors++; if (done_pulse !== 1'b0 || rx_q.size() != 0) begin errors++; $display("FAIL mid_rst_quiet got done=%b rx=%0d exp 0 0", done_pulse, rx_q.size()); end
    test_single(16'h1234, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic [8:0] got; logic [7:0] e;
    rx_q.delete();
    @(negedge clk); base = cyc;
    send_req = 1'b1; status_word = 16'h8123; push_pkt(16'h8123);
    to_cycle(1); send_req = 1'b0;
    to_cycle(50); send_req = 1'b1; status_word = 16'h0055;
    to_cycle(51); send_req = 1'b0;
    to_cycle(D); send_req = 1'b1; status_word = 16'h00AA; push_pkt(16'h00AA);
    to_cycle(D + 1); send_req = 1'b0;
    vectors++; if (uart_tx_pin !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got tx=%b busy=%b exp 0 1", uart_tx_pin, busy); end
    to_cycle(2 * D);
    vectors++; if (done_pulse !== 1'b1) begin errors++; $display("FAIL b2b_done got %b exp 1", done_pulse); end
    to_cycle(2 * D + 2);
    vectors++; if (busy !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%b overrun=%b exp 0 0", busy, overrun); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); e = exp_q.pop_front();
      vectors++; if (got !== {1'b1, e}) begin errors++; $display("FAIL b2b_byte got %h exp %h", got, {1'b1, e}); end
    end
    vectors++; if (rx_q.size() != 0 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_count got rx_left=%0d exp_left=%0d exp 0 0", rx_q.size(), exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single(16'h8123, 1'b1);
    test_pending();
    test_overrun();
    test_midreset();
    test_back_to_back();
    for (int k = 0; k < 3; k++) test_single(16'($urandom), 1'b0);
    test_single(16'h0000, 1'b0);
    test_single(16'hFFFF, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/chat2snack_status_tx.md
CHAT2SNACK_STATUS_TX -- requirements
Module: chat2snack_status_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  system clock, 50 MHz, rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 send_req  input  1  single-cycle request to transmit status_word.
REQ-006 status_word  input  16  status packet; bit 15 = system_busy, [14:0] = remaining amounts in the same field layout as the command word.
REQ-007 uart_tx_pin  output  1  serial line, 8N1, idle high.
REQ-008 busy  output  1  packet transmission in progress.
REQ-009 done_pulse  output  1  one-cycle strobe when a packet completes.
REQ-010 overrun  output  1  sticky flag: a pending request was overwritten.

Function
REQ-011 Packet byte order SHALL be low byte status_word[7:0] first, then high byte status_word[15:8]; each byte SHALL be LSB first.
REQ-012 Each byte frame SHALL be 1 start bit (0), 8 data bits, 1 stop bit (1), each bit held exactly CLKS_PER_BIT cycles.
REQ-013 FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT, DONE.
REQ-014 IDLE: send_req=1 latches status_word into a shadow register; uart_tx_pin goes low on the next cycle (START_BIT).
REQ-015 START_BIT -> DATA_BITS -> STOP_BIT after CLKS_PER_BIT cycles each; DATA_BITS uses a 3-bit index, 0..7, leaving after bit 7.
REQ-016 STOP_BIT: if bytes remain, go to START_BIT with no idle gap; otherwise go to DONE.
REQ-017 DONE lasts one cycle: done_pulse=1, busy=0, uart_tx_pin=1; next state is START_BIT if a request is pending or send_req=1, else IDLE.
REQ-018 busy SHALL be 1 from the cycle after acceptance through the last cycle of the final stop bit.
REQ-019 send_req while busy SHALL be stored in a one-deep pending register holding status_word at that time.
REQ-020 A further send_req while pending is valid SHALL overwrite the pending word and set overrun.
REQ-021 send_req in the DONE cycle SHALL take priority: its word is transmitted and any pending word is discarded without setting overrun.
REQ-022 Input status_word changes after acceptance SHALL NOT affect the frame in flight.
REQ-023 Bit-period counter width SHALL be sized for CLKS_PER_BIT-1 and SHALL not wrap mid-bit.

Reset
REQ-024 On rst: state IDLE, uart_tx_pin=1, busy=0, done_pulse=0, overrun=0, pending cleared, counters zero.
REQ-025 Reset asserted mid-frame SHALL abort it immediately, with line high and no done_pulse.
REQ-026 overrun SHALL clear only on reset.

Configuration
REQ-027 Macro STATUS_TX_CHECKSUM_EN defined: a third byte equal to status_word[7:0] XOR status_word[15:8] SHALL follow the high byte, framed as in REQ-012, before DONE.
REQ-028 Macro undefined: packets SHALL be exactly two bytes, with no checksum logic present.

Verification (CLKS_PER_BIT=4)
REQ-029 Send 0x8123 in IDLE at cycle 0 -> line low at cycle 1; bytes 0x23 then 0x81 LSB first; busy cycles 1..80; done_pulse at cycle 81.
REQ-030 Second send_req 0x0007 at cycle 40 -> after DONE of 0x8123, start bit of 0x0007 begins at cycle 82; overrun stays 0.
REQ-031 send_req 0x0001 at cycle 10 and 0x0002 at cycle 20 while busy -> overrun=1; the next packet transmitted is 0x0002.
REQ-032 rst asserted at cycle 30 mid-frame -> same cycle: uart_tx_pin=1, busy=0, no done_pulse; a fresh send_req afterwards transmits normally.
REQ-033 With STATUS_TX_CHECKSUM_EN, send 0x8123 -> third byte 0xA2; done_pulse at cycle 121.
